// File: rtl/incdec_operand_stage_if.sv
// incdec_operand_stage_if: operation request handshake plus IncDec operand/result bus.
// master: requester + IncDec side; slave: incdec_operand_stage.
interface incdec_operand_stage_if;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_src;
    logic [1:0]  op_dst;
    logic [1:0]  op_mode;
    logic [15:0] ext_addr;
    logic [7:0]  cbus;
    logic [7:0]  dbus;
    logic        ttb1;
    logic        ttb2;
    logic        ttb3;
    logic [7:0]  adl;
    logic [7:0]  adh;

    modport master (
        output op_valid, op_src, op_dst, op_mode, ext_addr,
        output adl, adh,
        input  op_ready, cbus, dbus, ttb1, ttb2, ttb3
    );

    modport slave (
        input  op_valid, op_src, op_dst, op_mode, ext_addr,
        input  adl, adh,
        output op_ready, cbus, dbus, ttb1, ttb2, ttb3
    );
endinterface

// File: rtl/incdec_operand_stage.sv
// incdec_operand_stage: PC/SP/WZ holder feeding IncDec over cbus/dbus, three-phase sequencer.
// Ports: CLK, RESET (sync, active-high), bus (slave: op handshake, cbus/dbus/ttb, adl/adh),
//   ld_en/ld_sel/ld_data direct load, result, done, pc, sp, wz.
// Option INCDEC_BUSKEEP_EN: cbus/dbus keep the last operand while IDLE instead of 8'h00.
module incdec_operand_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'h0000
) (
    input  logic                        CLK,
    input  logic                        RESET,
    incdec_operand_stage_if.slave       bus,
    input  logic                        ld_en,
    input  logic [1:0]                  ld_sel,
    input  logic [15:0]                 ld_data,
    output logic [15:0]                 result,
    output logic                        done,
    output logic [15:0]                 pc,
    output logic [15:0]                 sp,
    output logic [15:0]                 wz
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] opnd;
    logic [1:0]  dst_q;
    logic [1:0]  mode_q;
    logic [15:0] src_val;
    logic [15:0] cap_val;
    logic [15:0] pc_n;
    logic [15:0] sp_n;
    logic [15:0] wz_n;
    logic        accept;
    logic        cap;
    logic        drv_en;

    // IncDec returns its result inverted.
    assign cap_val = ~{bus.adh, bus.adl};
    assign accept  = bus.op_valid & bus.op_ready;
    assign cap     = (state == CAPTURE);

    always_comb begin
        state_n      = state;
        bus.op_ready = 1'b0;
        bus.ttb1     = 1'b0;
        bus.ttb2     = 1'b0;
        drv_en       = 1'b0;
        unique case (state)
            IDLE: begin
                bus.op_ready = 1'b1;
                if (bus.op_valid) state_n = DRIVE;
            end
            DRIVE, CAPTURE: begin
                drv_en   = 1'b1;
                bus.ttb2 = (mode_q == 2'd1);
                bus.ttb1 = (mode_q == 2'd2);
                state_n  = (state == DRIVE) ? CAPTURE : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ttb3 = 1'b0;

`ifdef INCDEC_BUSKEEP_EN
    // opnd only changes on accept, so outside DRIVE/CAPTURE it is the last operand.
    assign bus.cbus = opnd[7:0];
    assign bus.dbus = opnd[15:8];
`else
    assign bus.cbus = drv_en ? opnd[7:0]  : 8'h00;
    assign bus.dbus = drv_en ? opnd[15:8] : 8'h00;
`endif

    always_comb begin
        src_val = pc;
        unique case (bus.op_src)
            2'd0: src_val = pc;
            2'd1: src_val = sp;
            2'd2: src_val = wz;
            2'd3: src_val = bus.ext_addr;
            default: src_val = pc;
        endcase
    end

    // Capture overrides a same-cycle direct load to the same pair.
    always_comb begin
        pc_n = pc;
        sp_n = sp;
        wz_n = wz;
        if (ld_en && ld_sel == 2'd0) pc_n = ld_data;
        if (ld_en && ld_sel == 2'd1) sp_n = ld_data;
        if (ld_en && ld_sel == 2'd2) wz_n = ld_data;
        if (cap && dst_q == 2'd0) pc_n = cap_val;
        if (cap && dst_q == 2'd1) sp_n = cap_val;
        if (cap && dst_q == 2'd2) wz_n = cap_val;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            opnd   <= 16'h0000;
            dst_q  <= 2'd0;
            mode_q <= 2'd0;
            result <= 16'h0000;
            done   <= 1'b0;
            pc     <= RESET_PC;
            sp     <= RESET_SP;
            wz     <= 16'h0000;
        end else begin
            state <= state_n;
            done  <= cap;
            pc    <= pc_n;
            sp    <= sp_n;
            wz    <= wz_n;
            if (accept) begin
                opnd   <= src_val;
                dst_q  <= bus.op_dst;
                mode_q <= bus.op_mode;
            end
            if (cap) result <= cap_val;
        end
    end

endmodule

// File: tb/tb_incdec_operand_stage.sv
// tb_incdec_operand_stage: directed bench for incdec_operand_stage with a behavioural IncDec.
// Drives on negedge, samples on negedge; one task per scenario.
module tb_incdec_operand_stage;

    logic        CLK;
    logic        RESET;
    logic        ld_en;
    logic [1:0]  ld_sel;
    logic [15:0] ld_data;
    logic [15:0] result;
    logic        done;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] wz;
    logic [15:0] opd;
    logic [15:0] res;
    int          n_chk;
    int          n_fail;

    incdec_operand_stage_if bus ();

    incdec_operand_stage dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_sel  (ld_sel),
        .ld_data (ld_data),
        .result  (result),
        .done    (done),
        .pc      (pc),
        .sp      (sp),
        .wz      (wz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural IncDec: result returned with inverted polarity.
    always_comb begin
        opd = {bus.dbus, bus.cbus};
        if (bus.ttb2)      res = opd + 16'd1;
        else if (bus.ttb1) res = opd - 16'd1;
        else               res = opd;
        bus.adl = ~res[7:0];
        bus.adh = ~res[15:8];
    end

    task automatic ld(input logic [1:0] sel, input logic [15:0] data);
        @(negedge CLK);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_data = data;
        @(negedge CLK);
        ld_en   = 1'b0;
    endtask

    // Returns at the negedge inside DRIVE.
    task automatic issue(input logic [1:0] src, input logic [1:0] dst,
                         input logic [1:0] mode, input logic [15:0] ext);
        @(negedge CLK);
        bus.op_valid = 1'b1;
        bus.op_src   = src;
        bus.op_dst   = dst;
        bus.op_mode  = mode;
        bus.ext_addr = ext;
        @(negedge CLK);
        bus.op_valid = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        if (pc !== 16'h0000) begin
            $display("FAIL reset_pc: got %h want 0000", pc); n_fail++;
        end
        n_chk++;
        if (sp !== 16'h0000) begin
            $display("FAIL reset_sp: got %h want 0000", sp); n_fail++;
        end
        n_chk++;
        if (wz !== 16'h0000) begin
            $display("FAIL reset_wz: got %h want 0000", wz); n_fail++;
        end
        n_chk++;
        if ({bus.op_ready, done, bus.ttb1, bus.ttb2, bus.ttb3} !== 5'b10000) begin
            $display("FAIL reset_ctl: got rdy/done/t1/t2/t3=%b want 10000",
                     {bus.op_ready, done, bus.ttb1, bus.ttb2, bus.ttb3});
            n_fail++;
        end
        n_chk++;
        if ({bus.dbus, bus.cbus} !== 16'h0000 || result !== 16'h0000) begin
            $display("FAIL reset_bus: got bus=%h result=%h want 0000/0000",
                     {bus.dbus, bus.cbus}, result);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_inc;
        ld(2'd0, 16'h1234);
        issue(2'd0, 2'd0, 2'd1, 16'h0000);
        if ({bus.dbus, bus.cbus, bus.ttb2, bus.ttb1, bus.op_ready} !== {16'h1234, 3'b100}) begin
            $display("FAIL inc_drive: got d/c=%h t2/t1/rdy=%b want 1234 100",
                     {bus.dbus, bus.cbus}, {bus.ttb2, bus.ttb1, bus.op_ready});
            n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        if ({bus.dbus, bus.cbus, bus.ttb2} !== {16'h1234, 1'b1} || pc !== 16'h1234) begin
            $display("FAIL inc_capture: got d/c=%h t2=%b pc=%h want 1234 1 1234",
                     {bus.dbus, bus.cbus}, bus.ttb2, pc);
            n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        if (pc !== 16'h1235 || result !== 16'h1235 || done !== 1'b1) begin
            $display("FAIL inc_result: got pc=%h result=%h done=%b want 1235 1235 1",
                     pc, result, done);
            n_fail++;
        end
        n_chk++;
        if (bus.ttb2 !== 1'b0 || bus.op_ready !== 1'b1) begin
            $display("FAIL inc_idle: got ttb2=%b rdy=%b want 0 1", bus.ttb2, bus.op_ready);
            n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        if (done !== 1'b0) begin
            $display("FAIL inc_done_pulse: got %b want 0", done); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_dec_wrap;
        ld(2'd1, 16'h0000);
        issue(2'd1, 2'd1, 2'd2, 16'h0000);
        if ({bus.ttb1, bus.ttb2} !== 2'b10) begin
            $display("FAIL dec_ttb: got t1/t2=%b want 10", {bus.ttb1, bus.ttb2}); n_fail++;
        end
        n_chk++;
        repeat (2) @(negedge CLK);
        if (sp !== 16'hFFFF || result !== 16'hFFFF) begin
            $display("FAIL dec_wrap: got sp=%h result=%h want FFFF FFFF", sp, result);
            n_fail++;
        end
        n_chk++;
        ld(2'd0, 16'hFFFF);
        issue(2'd0, 2'd0, 2'd1, 16'h0000);
        repeat (2) @(negedge CLK);
        if (pc !== 16'h0000 || sp !== 16'hFFFF) begin
            $display("FAIL inc_wrap: got pc=%h sp=%h want 0000 FFFF", pc, sp); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_capture_vs_load;
        issue(2'd3, 2'd2, 2'd0, 16'hC000);
        if ({bus.ttb1, bus.ttb2} !== 2'b00 || {bus.dbus, bus.cbus} !== 16'hC000) begin
            $display("FAIL pass_drive: got t1/t2=%b bus=%h want 00 C000",
                     {bus.ttb1, bus.ttb2}, {bus.dbus, bus.cbus});
            n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        ld_en = 1'b1; ld_sel = 2'd2; ld_data = 16'hAAAA;
        @(negedge CLK);
        ld_en = 1'b0;
        if (wz !== 16'hC000) begin
            $display("FAIL capture_wins: got wz=%h want C000", wz); n_fail++;
        end
        n_chk++;
        issue(2'd0, 2'd3, 2'd1, 16'h0000);
        @(negedge CLK);
        ld_en = 1'b1; ld_sel = 2'd1; ld_data = 16'h5A5A;
        @(negedge CLK);
        ld_en = 1'b0;
        if (sp !== 16'h5A5A || result !== 16'h0001 || pc !== 16'h0000) begin
            $display("FAIL discard_ld: got sp=%h result=%h pc=%h want 5A5A 0001 0000",
                     sp, result, pc);
            n_fail++;
        end
        n_chk++;
        issue(2'd3, 2'd2, 2'd3, 16'h1357);
        if ({bus.ttb1, bus.ttb2} !== 2'b00) begin
            $display("FAIL rsvd_ttb: got t1/t2=%b want 00", {bus.ttb1, bus.ttb2}); n_fail++;
        end
        n_chk++;
        repeat (2) @(negedge CLK);
        if (wz !== 16'h1357) begin
            $display("FAIL rsvd_pass: got wz=%h want 1357", wz); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_reset_mid_op;
        ld(2'd0, 16'h1234);
        issue(2'd0, 2'd0, 2'd1, 16'h0000);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        if (pc !== 16'h0000 || sp !== 16'h0000 || wz !== 16'h0000 || result !== 16'h0000) begin
            $display("FAIL midreset_regs: got pc=%h sp=%h wz=%h result=%h want all 0000",
                     pc, sp, wz, result);
            n_fail++;
        end
        n_chk++;
        if ({bus.op_ready, done, bus.ttb2} !== 3'b100) begin
            $display("FAIL midreset_ctl: got rdy/done/t2=%b want 100",
                     {bus.op_ready, done, bus.ttb2});
            n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        if (done !== 1'b0 || pc !== 16'h0000) begin
            $display("FAIL midreset_nocap: got done=%b pc=%h want 0 0000", done, pc);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_back_to_back;
        ld(2'd2, 16'h0005);
        @(negedge CLK);
        bus.op_valid = 1'b1;
        bus.op_src   = 2'd2;
        bus.op_dst   = 2'd2;
        bus.op_mode  = 2'd1;
        @(negedge CLK);
        if (bus.op_ready !== 1'b0) begin
            $display("FAIL hold_drive_rdy: got %b want 0", bus.op_ready); n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        if (bus.op_ready !== 1'b0 || bus.ttb2 !== 1'b1) begin
            $display("FAIL hold_capture: got rdy=%b ttb2=%b want 0 1", bus.op_ready, bus.ttb2);
            n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        bus.op_valid = 1'b0;
        if (bus.op_ready !== 1'b1 || done !== 1'b1 || wz !== 16'h0006) begin
            $display("FAIL hold_single: got rdy=%b done=%b wz=%h want 1 1 0006",
                     bus.op_ready, done, wz);
            n_fail++;
        end
        n_chk++;
        repeat (3) @(negedge CLK);
        if (wz !== 16'h0006 || bus.op_ready !== 1'b1) begin
            $display("FAIL hold_no_second: got wz=%h rdy=%b want 0006 1", wz, bus.op_ready);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_buskeep;
        logic [15:0] exp_idle;
        ld(2'd0, 16'h1234);
        issue(2'd0, 2'd2, 2'd0, 16'h0000);
        repeat (2) @(negedge CLK);
`ifdef INCDEC_BUSKEEP_EN
        exp_idle = 16'h1234;
`else
        exp_idle = 16'h0000;
`endif
        if (wz !== 16'h1234) begin
            $display("FAIL keep_wz: got %h want 1234", wz); n_fail++;
        end
        n_chk++;
        @(negedge CLK);
        if ({bus.dbus, bus.cbus} !== exp_idle) begin
            $display("FAIL idle_bus: got %h want %h", {bus.dbus, bus.cbus}, exp_idle);
            n_fail++;
        end
        n_chk++;
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        RESET        = 1'b1;
        ld_en        = 1'b0;
        ld_sel       = 2'd0;
        ld_data      = 16'h0000;
        bus.op_valid = 1'b0;
        bus.op_src   = 2'd0;
        bus.op_dst   = 2'd0;
        bus.op_mode  = 2'd0;
        bus.ext_addr = 16'h0000;
        test_reset;
        test_inc;
        test_dec_wrap;
        test_capture_vs_load;
        test_reset_mid_op;
        test_back_to_back;
        test_buskeep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
